// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encoding shared by the pipelined barrel shifter and its stages.
package shifter_pkg;

    typedef logic [1:0] sh_mode_t;

    localparam sh_mode_t SH_SLL = 2'b00;
    localparam sh_mode_t SH_SRL = 2'b01;
    localparam sh_mode_t SH_SRA = 2'b10;
    localparam sh_mode_t SH_ROR = 2'b11;

endpackage

// File: rtl/shifter_stage.sv
// shifter_stage: one conditional shift-by-STEP pipeline stage with valid/advance control.
// Rotate wrap is built only when SHIFTER_ROTATE_EN is defined; otherwise mode 11 shifts left.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  sh_mode_t         i_mode,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_next_load,
    output logic             o_load,
    output logic             o_valid,
    output sh_mode_t         o_mode,
    output logic [AMT_W-1:0] o_amt,
    output logic [WIDTH-1:0] o_data
);

    localparam int BIT = $clog2(STEP);

    logic             r_valid;
    sh_mode_t         r_mode;
    logic [AMT_W-1:0] r_amt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_data;

    always_comb begin
        w_shifted = i_data << STEP;
        if (i_mode == SH_SRL)
            w_shifted = i_data >> STEP;
        else if (i_mode == SH_SRA)
            w_shifted = $signed(i_data) >>> STEP;
`ifdef SHIFTER_ROTATE_EN
        else if (i_mode == SH_ROR)
            w_shifted = {i_data[STEP-1:0], i_data[WIDTH-1:STEP]};
`endif
    end

    assign w_data = i_amt[BIT] ? w_shifted : i_data;
    // Empty stages always load, so bubbles collapse toward the output.
    assign o_load = !r_valid || i_next_load;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_mode  <= SH_SLL;
            r_amt   <= '0;
            r_data  <= '0;
        end else if (o_load) begin
            r_valid <= i_valid;
            r_mode  <= i_mode;
            r_amt   <= i_amt;
            r_data  <= w_data;
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_amt   = r_amt;
    assign o_data  = r_data;

endmodule

// File: rtl/shifter_pipe_barrel.sv
// shifter_pipe_barrel: log2(WIDTH)-stage pipelined barrel shifter with valid/ready flow control.
// Define SHIFTER_ROTATE_EN to make mode 11 rotate right; otherwise it executes as SLL.
module shifter_pipe_barrel
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  sh_mode_t         SH_MODE,
    input  logic [AMT_W-1:0] SH_AMT,
    input  logic [WIDTH-1:0] D_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D_OUT
);

    logic             w_valid [AMT_W+1];
    logic             w_load  [AMT_W+1];
    sh_mode_t         w_mode  [AMT_W+1];
    logic [AMT_W-1:0] w_amt   [AMT_W+1];
    logic [WIDTH-1:0] w_data  [AMT_W+1];
    logic             w_unused;

    assign w_valid[0]     = IN_VALID;
    assign w_mode[0]      = SH_MODE;
    assign w_amt[0]       = SH_AMT;
    assign w_data[0]      = D_IN;
    assign w_load[AMT_W]  = OUT_READY;

    generate
        for (genvar k = 0; k < AMT_W; k++) begin : g_stage
            shifter_stage #(
                .WIDTH (WIDTH),
                .STEP  (1 << k),
                .AMT_W (AMT_W)
            ) u_stage (
                .i_clk       (CLK),
                .i_rst       (RST),
                .i_valid     (w_valid[k]),
                .i_mode      (w_mode[k]),
                .i_amt       (w_amt[k]),
                .i_data      (w_data[k]),
                .i_next_load (w_load[k+1]),
                .o_load      (w_load[k]),
                .o_valid     (w_valid[k+1]),
                .o_mode      (w_mode[k+1]),
                .o_amt       (w_amt[k+1]),
                .o_data      (w_data[k+1])
            );
        end
    endgenerate

    // The last stage's mode and amount have no consumer.
    assign w_unused  = ^{w_mode[AMT_W], w_amt[AMT_W]};
    assign IN_READY  = w_load[0];
    assign OUT_VALID = w_valid[AMT_W];
    assign D_OUT     = w_data[AMT_W];

endmodule

// File: tb/tb_shifter_pipe_barrel.sv
// tb_shifter_pipe_barrel: scoreboard bench for 32- and 8-bit shifter pipes.
// Expected ROR behaviour follows SHIFTER_ROTATE_EN, matching the RTL build.
module tb_shifter_pipe_barrel;
    import shifter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v32 = 0, rdy32, ov32, ordy32 = 0;
    sh_mode_t    m32 = SH_SLL;
    logic [4:0]  a32 = '0;
    logic [31:0] d32 = '0, dout32;

    logic        v8 = 0, rdy8, ov8, ordy8 = 0;
    sh_mode_t    m8 = SH_SLL;
    logic [2:0]  a8 = '0;
    logic [7:0]  d8 = '0, dout8;

    int errors = 0, checks = 0, acc = 0, outs = 0;
    logic [31:0] sb[$];
    logic [7:0]  sb8[$];

    shifter_pipe_barrel #(.WIDTH(32)) u32 (
        .CLK(clk), .RST(rst), .IN_VALID(v32), .IN_READY(rdy32), .SH_MODE(m32), .SH_AMT(a32),
        .D_IN(d32), .OUT_VALID(ov32), .OUT_READY(ordy32), .D_OUT(dout32)
    );

    shifter_pipe_barrel #(.WIDTH(8)) u8 (
        .CLK(clk), .RST(rst), .IN_VALID(v8), .IN_READY(rdy8), .SH_MODE(m8), .SH_AMT(a8),
        .D_IN(d8), .OUT_VALID(ov8), .OUT_READY(ordy8), .D_OUT(dout8)
    );

    // Reference: repeated single-bit shifts within a w-bit word.
    function automatic logic [31:0] model(int w, logic [31:0] d, sh_mode_t m, int amt);
        logic [31:0] msb = 32'd1 << (w - 1);
        logic [31:0] r = d;
        for (int i = 0; i < amt; i++) begin
            case (m)
                SH_SRL: r = r >> 1;
                SH_SRA: r = (r >> 1) | (r & msb);
`ifdef SHIFTER_ROTATE_EN
                SH_ROR: r = (r >> 1) | ((r & 32'd1) << (w - 1));
`endif
                default: r = (r << 1) & ((msb << 1) - 32'd1);
            endcase
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc32(logic v, sh_mode_t m, logic [4:0] a, logic [31:0] d, logic ordy);
        v32 = v; m32 = m; a32 = a; d32 = d; ordy32 = ordy;
        #1;
        if (v32 && rdy32) begin
            sb.push_back(model(32, d, m, int'(a)));
            acc++;
        end
        if (ov32 && ordy32) begin
            outs++;
            if (sb.size() == 0) chk("spurious32", 32'd1, 32'd0);
            else chk("dout32", dout32, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc8(logic v, sh_mode_t m, logic [2:0] a, logic [7:0] d, logic ordy);
        logic [31:0] t;
        v8 = v; m8 = m; a8 = a; d8 = d; ordy8 = ordy;
        #1;
        if (v8 && rdy8) begin
            t = model(8, 32'(d), m, int'(a));
            sb8.push_back(t[7:0]);
        end
        if (ov8 && ordy8) begin
            if (sb8.size() == 0) chk("spurious8", 32'd1, 32'd0);
            else chk("dout8", 32'(dout8), 32'(sb8.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain32();
        for (int i = 0; i < 30 && (sb.size() > 0 || ov32); i++) cyc32(0, SH_SLL, 5'd0, 32'd0, 1);
        chk("drain32_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic drain8();
        for (int i = 0; i < 30 && (sb8.size() > 0 || ov8); i++) cyc8(0, SH_SLL, 3'd0, 8'd0, 1);
        chk("drain8_left", 32'(sb8.size()), 32'd0);
    endtask

    sh_mode_t    pm [8];
    logic [4:0]  pa [8];
    logic [31:0] pd [8];
    logic [31:0] held;
    int p, a0, o0;

    initial begin
        #3;
        chk("rst_out_valid", 32'(ov32), 32'd0);
        chk("rst_d_out", dout32, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(rdy32), 32'd1);
        @(posedge clk);
        #1;

        // Latency: valid appears after the fifth edge counting the acceptance edge.
        cyc32(1, SH_SLL, 5'd31, 32'h0000_0001, 1);
        for (int e = 1; e <= 5; e++) begin
            chk("lat32_valid", 32'(ov32), 32'(e == 5));
            cyc32(0, SH_SLL, 5'd0, 32'd0, 1);
        end
        drain32();

        cyc32(1, SH_SRA, 5'd4, 32'h8000_0000, 1);
        cyc32(1, SH_SRL, 5'd4, 32'h8000_0000, 1);
        for (int m = 0; m < 4; m++) cyc32(1, sh_mode_t'(m), 5'd0, 32'h8000_0000, 1);
        cyc32(1, SH_ROR, 5'd1, 32'h0000_0001, 1);
        cyc32(1, SH_ROR, 5'd31, 32'hA5A5_0F0F, 1);
        cyc32(1, SH_SRA, 5'd31, 32'h8000_0001, 1);
        cyc32(1, SH_SRA, 5'd7, 32'h7FFF_FFFF, 1);
        cyc32(1, SH_SLL, 5'd16, 32'h1234_5678, 1);
        cyc32(1, SH_SRL, 5'd31, 32'hFFFF_FFFF, 1);
        drain32();

        // Backpressure: seven ops offered into a stalled pipe.
        for (int i = 0; i < 8; i++) begin
            pm[i] = sh_mode_t'(i % 4);
            pa[i] = 5'(3 * i + 1);
            pd[i] = 32'hC001_0000 + 32'(i * 32'h1111);
        end
        p = 0;
        a0 = acc;
        for (int i = 0; i < 7; i++) begin
            o0 = acc;
            cyc32(p < 7, pm[p], pa[p], pd[p], 0);
            if (acc != o0) p++;
        end
        chk("bp_accepted", 32'(acc - a0), 32'd5);
        chk("bp_in_ready", 32'(rdy32), 32'd0);
        chk("bp_out_valid", 32'(ov32), 32'd1);
        held = dout32;
        for (int i = 0; i < 2; i++) begin
            cyc32(1, pm[p], pa[p], pd[p], 0);
            chk("bp_hold", dout32, held);
        end
        o0 = outs;
        for (int i = 0; i < 7; i++) begin
            a0 = acc;
            cyc32(p < 7, pm[p], pa[p], pd[p], 1);
            if (acc != a0) p++;
        end
        chk("bp_out_count", 32'(outs - o0), 32'd7);
        chk("bp_all_taken", 32'(p), 32'd7);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        drain32();

        // Asynchronous reset with three operations in flight.
        for (int i = 0; i < 3; i++) cyc32(1, SH_SRL, 5'(i + 1), 32'hFFFF_0000, 0);
        cyc32(0, SH_SLL, 5'd0, 32'd0, 0);
        cyc32(0, SH_SLL, 5'd0, 32'd0, 0);
        chk("mid_out_valid", 32'(ov32), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(ov32), 32'd0);
        chk("async_d_out", dout32, 32'd0);
        sb.delete();
        #1 rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(rdy32), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc32(0, SH_SLL, 5'd0, 32'd0, 1);
            chk("no_stale", 32'(ov32), 32'd0);
        end

        // WIDTH=8: latency 3 then a random stream with random backpressure.
        cyc8(1, SH_SRA, 3'd3, 8'h90, 1);
        for (int e = 1; e <= 3; e++) begin
            chk("lat8_valid", 32'(ov8), 32'(e == 3));
            cyc8(0, SH_SLL, 3'd0, 8'd0, 1);
        end
        drain8();
        for (int i = 0; i < 80; i++)
            cyc8(1'($urandom_range(0, 1)), sh_mode_t'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 8'($urandom), $urandom_range(0, 3) != 0);
        drain8();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
